// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction fetch stage with IF/ID register and load-use detection
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        branch_taken,
    input  logic [15:0] branch_imm16,
    input  logic        ex_mem_to_reg,
    input  logic [4:0]  ex_rt,
    input  logic        ext_stall,
    output logic [31:0] pc,
    output logic [31:0] ifid_inst,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        bubble
);

    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        hazard;
    logic        stall;
    logic        redirect;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;

    assign id_rs = ifid_inst[25:21];
    assign id_rt = ifid_inst[20:16];

    // rt is compared even for I-type consumers; an occasional spurious stall is harmless
    assign hazard = ifid_valid & ex_mem_to_reg & (ex_rt != 5'd0)
                  & ((ex_rt == id_rs) | (ex_rt == id_rt));

    assign bubble   = hazard;
    assign stall    = hazard | ext_stall;
    assign redirect = branch_taken & ifid_valid & ~stall;

    assign pc_plus4      = pc + 32'd4;
    assign branch_target = ifid_pc4 + {{14{branch_imm16[15]}}, branch_imm16, 2'b00};
    assign imem_addr     = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            ifid_inst  <= 32'h0;
            ifid_pc4   <= 32'h0;
            ifid_valid <= 1'b0;
        end else if (stall) begin
            // freeze: a branch in ID waits for its operands and is re-evaluated next cycle
            pc         <= pc;
            ifid_inst  <= ifid_inst;
            ifid_pc4   <= ifid_pc4;
            ifid_valid <= ifid_valid;
        end else if (redirect) begin
            // squash the wrong-path fetch with sll $0 NOP
            pc         <= branch_target;
            ifid_inst  <= 32'h0;
            ifid_pc4   <= pc_plus4;
            ifid_valid <= 1'b0;
        end else begin
            pc         <= pc_plus4;
            ifid_inst  <= imem_data;
            ifid_pc4   <= pc_plus4;
            ifid_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed testbench for if_stage
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        branch_taken;
    logic [15:0] branch_imm16;
    logic        ex_mem_to_reg;
    logic [4:0]  ex_rt;
    logic        ext_stall;

    logic [31:0] imem_addr, imem_data, pc, ifid_inst, ifid_pc4;
    logic        ifid_valid, bubble;
    logic [31:0] w_imem_addr, w_imem_data, w_pc, w_ifid_inst, w_ifid_pc4;
    logic        w_ifid_valid, w_bubble;

    logic [31:0] mem [0:63];
    int checks;
    int failures;

    assign imem_data   = mem[imem_addr[7:2]];
    assign w_imem_data = mem[w_imem_addr[7:2]];

    if_stage #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .branch_taken(branch_taken), .branch_imm16(branch_imm16),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_rt(ex_rt), .ext_stall(ext_stall),
        .pc(pc), .ifid_inst(ifid_inst), .ifid_pc4(ifid_pc4),
        .ifid_valid(ifid_valid), .bubble(bubble)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst), .imem_addr(w_imem_addr), .imem_data(w_imem_data),
        .branch_taken(branch_taken), .branch_imm16(branch_imm16),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_rt(ex_rt), .ext_stall(ext_stall),
        .pc(w_pc), .ifid_inst(w_ifid_inst), .ifid_pc4(w_ifid_pc4),
        .ifid_valid(w_ifid_valid), .bubble(w_bubble)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        branch_taken  = 1'b0;
        branch_imm16  = 16'h0;
        ex_mem_to_reg = 1'b0;
        ex_rt         = 5'd0;
        ext_stall     = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc actual=%h expected=%h", pc, 32'h0); end
        checks++; if (ifid_valid !== 1'b0 || ifid_inst !== 32'h0 || ifid_pc4 !== 32'h0 || bubble !== 1'b0) begin
            failures++; $display("FAIL reset_ifid actual=%b/%h/%h/%b expected=0/0/0/0", ifid_valid, ifid_inst, ifid_pc4, bubble); end
        checks++; if (w_pc !== 32'hFFFF_FFFC || w_imem_addr !== 32'hFFFF_FFFC) begin
            failures++; $display("FAIL reset_wrap_pc actual=%h/%h expected=fffffffc", w_pc, w_imem_addr); end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if (ifid_inst !== 32'(k) || ifid_pc4 !== 32'(4 * k) || ifid_valid !== 1'b1 || pc !== 32'(4 * k)) begin
                failures++;
                $display("FAIL seq_fetch_%0d actual=%h/%h/%b/%h expected=%h/%h/1/%h",
                         k, ifid_inst, ifid_pc4, ifid_valid, pc, 32'(k), 32'(4 * k), 32'(4 * k));
            end
        end
    endtask

    task automatic test_branch_neg();
        do_reset();
        repeat (5) step();
        checks++; if (ifid_pc4 !== 32'h14 || ifid_inst !== 32'd5) begin
            failures++; $display("FAIL br_setup actual=%h/%h expected=00000014/00000005", ifid_pc4, ifid_inst); end
        branch_taken = 1'b1; branch_imm16 = 16'hFFFB;
        step();
        branch_taken = 1'b0;
        checks++; if (pc !== 32'h0 || ifid_valid !== 1'b0 || ifid_inst !== 32'h0 || ifid_pc4 !== 32'h18) begin
            failures++; $display("FAIL br_edge1 actual=%h/%b/%h/%h expected=0/0/0/18", pc, ifid_valid, ifid_inst, ifid_pc4); end
        step();
        checks++; if (ifid_inst !== 32'd1 || ifid_pc4 !== 32'h4 || ifid_valid !== 1'b1 || pc !== 32'h4) begin
            failures++; $display("FAIL br_edge2 actual=%h/%h/%b/%h expected=1/4/1/4", ifid_inst, ifid_pc4, ifid_valid, pc); end
    endtask

    task automatic test_load_use();
        do_reset();
        repeat (9) step();
        checks++; if (ifid_inst !== 32'h0109_5020 || pc !== 32'h24) begin
            failures++; $display("FAIL lu_setup actual=%h/%h expected=01095020/00000024", ifid_inst, pc); end
        ex_mem_to_reg = 1'b1; ex_rt = 5'd8; #1;
        checks++; if (bubble !== 1'b1) begin failures++; $display("FAIL lu_bubble_rs actual=%b expected=1", bubble); end
        ex_rt = 5'd9; #1;
        checks++; if (bubble !== 1'b1) begin failures++; $display("FAIL lu_bubble_rt actual=%b expected=1", bubble); end
        ex_rt = 5'd10; #1;
        checks++; if (bubble !== 1'b0) begin failures++; $display("FAIL lu_rd_nohaz actual=%b expected=0", bubble); end
        ex_rt = 5'd0; #1;
        checks++; if (bubble !== 1'b0) begin failures++; $display("FAIL lu_zero_nohaz actual=%b expected=0", bubble); end
        ex_rt = 5'd8; #1;
        step();
        checks++; if (pc !== 32'h24 || ifid_inst !== 32'h0109_5020 || ifid_pc4 !== 32'h24 || ifid_valid !== 1'b1) begin
            failures++; $display("FAIL lu_hold actual=%h/%h/%h/%b expected=24/01095020/24/1", pc, ifid_inst, ifid_pc4, ifid_valid); end
        ex_mem_to_reg = 1'b0;
        step();
        checks++; if (pc !== 32'h28 || ifid_inst !== 32'd10) begin
            failures++; $display("FAIL lu_resume actual=%h/%h expected=28/0000000a", pc, ifid_inst); end
        ex_mem_to_reg = 1'b1; ex_rt = 5'd0;
        step();
        checks++; if (pc !== 32'h2C || ifid_inst !== 32'd11) begin
            failures++; $display("FAIL lu_rt0_nostall actual=%h/%h expected=2c/0000000b", pc, ifid_inst); end
        ex_mem_to_reg = 1'b0;
    endtask

    task automatic test_stall_vs_branch();
        do_reset();
        repeat (9) step();
        ex_mem_to_reg = 1'b1; ex_rt = 5'd9;
        branch_taken = 1'b1; branch_imm16 = 16'h0002;
        step();
        checks++; if (pc !== 32'h24 || ifid_valid !== 1'b1 || ifid_inst !== 32'h0109_5020) begin
            failures++; $display("FAIL svb_hold actual=%h/%b/%h expected=24/1/01095020", pc, ifid_valid, ifid_inst); end
        ex_mem_to_reg = 1'b0;
        step();
        branch_taken = 1'b0;
        checks++; if (pc !== 32'h2C || ifid_valid !== 1'b0 || ifid_inst !== 32'h0 || ifid_pc4 !== 32'h28) begin
            failures++; $display("FAIL svb_redirect actual=%h/%b/%h/%h expected=2c/0/0/28", pc, ifid_valid, ifid_inst, ifid_pc4); end
    endtask

    task automatic test_ext_stall();
        do_reset();
        repeat (2) step();
        ext_stall = 1'b1;
        repeat (3) step();
        checks++; if (pc !== 32'h8 || ifid_inst !== 32'd2 || ifid_pc4 !== 32'h8 || bubble !== 1'b0) begin
            failures++; $display("FAIL ext_hold actual=%h/%h/%h/%b expected=8/2/8/0", pc, ifid_inst, ifid_pc4, bubble); end
        ext_stall = 1'b0;
        step();
        checks++; if (pc !== 32'hC || ifid_inst !== 32'd3) begin
            failures++; $display("FAIL ext_resume actual=%h/%h expected=c/3", pc, ifid_inst); end
    endtask

    task automatic test_wrap();
        do_reset();
        step();
        checks++; if (w_pc !== 32'h0 || w_ifid_pc4 !== 32'h0 || w_ifid_inst !== 32'd64 || w_ifid_valid !== 1'b1) begin
            failures++; $display("FAIL wrap_first actual=%h/%h/%h/%b expected=0/0/40/1", w_pc, w_ifid_pc4, w_ifid_inst, w_ifid_valid); end
        branch_taken = 1'b1; branch_imm16 = 16'hFFFA;
        step();
        branch_taken = 1'b0;
        checks++; if (pc !== 32'hFFFF_FFEC) begin failures++; $display("FAIL wrap_back actual=%h expected=ffffffec", pc); end
        step();
        checks++; if (ifid_pc4 !== 32'hFFFF_FFF0 || ifid_inst !== 32'd60) begin
            failures++; $display("FAIL wrap_high_fetch actual=%h/%h expected=fffffff0/3c", ifid_pc4, ifid_inst); end
        branch_taken = 1'b1; branch_imm16 = 16'h0008;
        step();
        branch_taken = 1'b0;
        checks++; if (pc !== 32'h0000_0010) begin failures++; $display("FAIL wrap_target actual=%h expected=00000010", pc); end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (4) step();
        #2;
        rst = 1'b1;
        #1;
        checks++; if (pc !== 32'h0 || imem_addr !== 32'h0 || ifid_valid !== 1'b0 || ifid_inst !== 32'h0 || ifid_pc4 !== 32'h0) begin
            failures++; $display("FAIL async_rst actual=%h/%h/%b/%h/%h expected=0/0/0/0/0", pc, imem_addr, ifid_valid, ifid_inst, ifid_pc4); end
        step();
        rst = 1'b0;
        step();
        checks++; if (ifid_inst !== 32'd1 || pc !== 32'h4 || ifid_valid !== 1'b1) begin
            failures++; $display("FAIL async_restart actual=%h/%h/%b expected=1/4/1", ifid_inst, pc, ifid_valid); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'(i + 1);
        mem[8] = 32'h0109_5020;
        rst = 1'b1;
        test_reset();
        test_sequential();
        test_branch_neg();
        test_load_use();
        test_stall_vs_branch();
        test_ext_stall();
        test_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
